instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 11 +
 rtl/instr_fetch_queue_ram.sv | 26 ++
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 tb/tb_instr_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared constants and entry type for the instruction fetch queue
package instr_fetch_queue_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_ram.sv
// rtl/instr_fetch_queue_ram.sv - instr_queue_ram: DEPTH x 64-bit storage, sync write, async read
module instr_queue_ram
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  iq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output iq_entry_t                rdata
);

    iq_entry_t mem [DEPTH];

    // Contents are deliberately not reset; occupancy tracking masks stale data.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - first-word-fall-through fetch-to-decode instruction queue
// Optional combinational empty-queue bypass enabled by defining QUEUE_BYPASS_EN.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            Instr_IN,
    input  logic [31:0]            Instr_PC_IN,
    input  logic                   Instr_Valid_IN,
    output logic                   Full_OUT,
    input  logic                   Request_Instr1,
    input  logic                   Freeze_IN,
    input  logic                   Flush_IN,
    output logic [31:0]            Instr1_OUT,
    output logic [31:0]            Instr1_PC_OUT,
    output logic [31:0]            Instr1_PC_Plus4_OUT,
    output logic                   Instr1_Valid_OUT,
    output logic [$clog2(DEPTH):0] Count_OUT
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          full;
    logic          empty;
    logic          bypass;
    logic          push_ok;
    logic          pop_fire;
    logic          head_pop;
    logic          store;
    iq_entry_t     wr_entry;
    iq_entry_t     rd_entry;

    assign empty    = (count == '0);
    assign wr_entry = '{instr: Instr_IN, pc: Instr_PC_IN};

`ifdef QUEUE_BYPASS_EN
    assign bypass = empty && Instr_Valid_IN && !Flush_IN;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        Instr1_Valid_OUT = 1'b0;
        Instr1_OUT       = '0;
        Instr1_PC_OUT    = '0;
        if (!empty) begin
            Instr1_Valid_OUT = 1'b1;
            Instr1_OUT       = rd_entry.instr;
            Instr1_PC_OUT    = rd_entry.pc;
        end else if (bypass) begin
            Instr1_Valid_OUT = 1'b1;
            Instr1_OUT       = Instr_IN;
            Instr1_PC_OUT    = Instr_PC_IN;
        end
    end

    assign Instr1_PC_Plus4_OUT = Instr1_PC_OUT + 32'd4;

    assign push_ok  = Instr_Valid_IN && !full && !Flush_IN;
    assign pop_fire = Instr1_Valid_OUT && Request_Instr1 && !Freeze_IN && !Flush_IN;
    assign head_pop = pop_fire && !empty;
    // A bypassed word consumed in the same cycle never enters storage.
    assign store    = push_ok && !(bypass && pop_fire);

    always_comb begin
        count_nxt = count;
        if (Flush_IN) begin
            count_nxt = '0;
        end else if (store && !head_pop) begin
            count_nxt = count + 1'b1;
        end else if (!store && head_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            if (Flush_IN) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (store)    tail <= tail + 1'b1;
                if (head_pop) head <= head + 1'b1;
            end
        end
    end

    instr_queue_ram #(.DEPTH(DEPTH)) u_ram (
        .CLK   (CLK),
        .we    (store),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    assign Full_OUT  = full;
    assign Count_OUT = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue (DEPTH=8)
module tb_instr_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr_IN;
    logic [31:0] Instr_PC_IN;
    logic        Instr_Valid_IN;
    logic        Full_OUT;
    logic        Request_Instr1;
    logic        Freeze_IN;
    logic        Flush_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr1_PC_OUT;
    logic [31:0] Instr1_PC_Plus4_OUT;
    logic        Instr1_Valid_OUT;
    logic [3:0]  Count_OUT;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue #(.DEPTH(8)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .Instr_IN            (Instr_IN),
        .Instr_PC_IN         (Instr_PC_IN),
        .Instr_Valid_IN      (Instr_Valid_IN),
        .Full_OUT            (Full_OUT),
        .Request_Instr1      (Request_Instr1),
        .Freeze_IN           (Freeze_IN),
        .Flush_IN            (Flush_IN),
        .Instr1_OUT          (Instr1_OUT),
        .Instr1_PC_OUT       (Instr1_PC_OUT),
        .Instr1_PC_Plus4_OUT (Instr1_PC_Plus4_OUT),
        .Instr1_Valid_OUT    (Instr1_Valid_OUT),
        .Count_OUT           (Count_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
        Instr_IN = instr; Instr_PC_IN = pc; Instr_Valid_IN = 1'b1;
        step();
        Instr_Valid_IN = 1'b0;
    endtask

    task automatic drain();
        Request_Instr1 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        Request_Instr1 = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; Instr_IN = '0; Instr_PC_IN = '0; Instr_Valid_IN = 1'b0;
        Request_Instr1 = 1'b0; Freeze_IN = 1'b0; Flush_IN = 1'b0;
        #2;
        checks++; if (Count_OUT !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count_OUT); end
        checks++; if (Full_OUT !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", Full_OUT); end
        checks++; if (Instr1_Valid_OUT !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Instr1_Valid_OUT); end
        checks++; if (Instr1_OUT !== 32'h0 || Instr1_PC_OUT !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", Instr1_OUT, Instr1_PC_OUT); end
        step(); step();
        RESET = 1'b1;
        step();
    endtask

    task automatic test_single_push();
        Instr_IN = 32'h20080005; Instr_PC_IN = 32'h00400000; Instr_Valid_IN = 1'b1;
        #1;
`ifndef QUEUE_BYPASS_EN
        checks++; if (Instr1_Valid_OUT !== 1'b0) begin errors++; $display("FAIL single_no_comb_path got %b exp 0", Instr1_Valid_OUT); end
`endif
        step();
        Instr_Valid_IN = 1'b0;
        checks++; if (Instr1_Valid_OUT !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", Instr1_Valid_OUT); end
        checks++; if (Instr1_OUT !== 32'h20080005) begin errors++; $display("FAIL single_instr got %h exp 20080005", Instr1_OUT); end
        checks++; if (Instr1_PC_Plus4_OUT !== 32'h00400004) begin errors++; $display("FAIL single_plus4 got %h exp 00400004", Instr1_PC_Plus4_OUT); end
        checks++; if (Count_OUT !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", Count_OUT); end
        Request_Instr1 = 1'b1;
        step();
        Request_Instr1 = 1'b0;
        checks++; if (Count_OUT !== 4'd0 || Instr1_Valid_OUT !== 1'b0 || Instr1_OUT !== 32'h0) begin
            errors++; $display("FAIL single_pop_empty got cnt=%0d v=%b i=%h exp 0/0/0", Count_OUT, Instr1_Valid_OUT, Instr1_OUT); end
        Request_Instr1 = 1'b1;
        step();
        Request_Instr1 = 1'b0;
        checks++; if (Count_OUT !== 4'd0) begin errors++; $display("FAIL pop_when_empty got %0d exp 0", Count_OUT); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        for (int i = 0; i < 8; i++) push1(32'h1000 + i, 32'h00400000 + 4 * i);
        checks++; if (Full_OUT !== 1'b1 || Count_OUT !== 4'd8) begin errors++; $display("FAIL full_after8 got f=%b cnt=%0d exp 1/8", Full_OUT, Count_OUT); end
        push1(32'hDEAD0001, 32'h00400020);
        checks++; if (Count_OUT !== 4'd8) begin errors++; $display("FAIL full_drop9 got %0d exp 8", Count_OUT); end
        // push while full plus pop: push must still be dropped
        Instr_IN = 32'hDEAD0002; Instr_PC_IN = 32'h00400024; Instr_Valid_IN = 1'b1; Request_Instr1 = 1'b1;
        checks++; if (Instr1_PC_OUT !== 32'h00400000) begin errors++; $display("FAIL full_pop0_pc got %h exp 00400000", Instr1_PC_OUT); end
        step();
        Instr_Valid_IN = 1'b0;
        checks++; if (Count_OUT !== 4'd7 || Full_OUT !== 1'b0) begin errors++; $display("FAIL full_pushpop got cnt=%0d f=%b exp 7/0", Count_OUT, Full_OUT); end
        for (int i = 1; i < 8; i++) begin
            exp_pc = 32'h00400000 + 4 * i;
            checks++; if (Instr1_PC_OUT !== exp_pc || Instr1_OUT !== 32'h1000 + i) begin
                errors++; $display("FAIL full_order%0d got %h/%h exp %h/%h", i, Instr1_PC_OUT, Instr1_OUT, exp_pc, 32'h1000 + i); end
            step();
        end
        Request_Instr1 = 1'b0;
        checks++; if (Count_OUT !== 4'd0 || Instr1_Valid_OUT !== 1'b0) begin errors++; $display("FAIL full_drained got cnt=%0d v=%b exp 0/0", Count_OUT, Instr1_Valid_OUT); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) push1(32'h2000 + i, 32'h00000100 + 4 * i);
        checks++; if (Count_OUT !== 4'd4) begin errors++; $display("FAIL flush_pre got %0d exp 4", Count_OUT); end
        Instr_IN = 32'hBAD00000; Instr_PC_IN = 32'h00000200; Instr_Valid_IN = 1'b1; Request_Instr1 = 1'b1; Flush_IN = 1'b1;
        step();
        Instr_Valid_IN = 1'b0; Request_Instr1 = 1'b0; Flush_IN = 1'b0;
        checks++; if (Count_OUT !== 4'd0 || Instr1_Valid_OUT !== 1'b0) begin errors++; $display("FAIL flush_clear got cnt=%0d v=%b exp 0/0", Count_OUT, Instr1_Valid_OUT); end
        push1(32'h3000, 32'h00000300);
        checks++; if (Count_OUT !== 4'd1 || Instr1_PC_OUT !== 32'h00000300) begin errors++; $display("FAIL flush_after got cnt=%0d pc=%h exp 1/00000300", Count_OUT, Instr1_PC_OUT); end
        drain();
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 3; i++) push1(32'h4000 + i, 32'h00000400 + 4 * i);
        Freeze_IN = 1'b1; Request_Instr1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (Count_OUT !== 4'd3 || Instr1_PC_OUT !== 32'h00000400) begin
                errors++; $display("FAIL freeze_hold%0d got cnt=%0d pc=%h exp 3/00000400", c, Count_OUT, Instr1_PC_OUT); end
        end
        Freeze_IN = 1'b0;
        step();
        Request_Instr1 = 1'b0;
        checks++; if (Count_OUT !== 4'd2 || Instr1_PC_OUT !== 32'h00000404) begin errors++; $display("FAIL freeze_release got cnt=%0d pc=%h exp 2/00000404", Count_OUT, Instr1_PC_OUT); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        push1(32'h5000, 32'h00001000);
        push1(32'h5001, 32'h00001004);
        Request_Instr1 = 1'b1; Instr_Valid_IN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            Instr_IN = 32'h5002 + c; Instr_PC_IN = 32'h00001008 + 4 * c;
            exp_pc = 32'h00001000 + 4 * c;
            checks++; if (Instr1_PC_OUT !== exp_pc || Instr1_OUT !== 32'h5000 + c) begin
                errors++; $display("FAIL stream_order%0d got %h/%h exp %h/%h", c, Instr1_PC_OUT, Instr1_OUT, exp_pc, 32'h5000 + c); end
            step();
            checks++; if (Count_OUT !== 4'd2) begin errors++; $display("FAIL stream_count%0d got %0d exp 2", c, Count_OUT); end
        end
        Instr_Valid_IN = 1'b0;
        checks++; if (Instr1_PC_OUT !== 32'h00001050) begin errors++; $display("FAIL stream_tail got %h exp 00001050", Instr1_PC_OUT); end
        drain();
    endtask

    task automatic test_plus4_wrap();
        push1(32'h6000, 32'hFFFFFFFC);
        checks++; if (Instr1_PC_Plus4_OUT !== 32'h00000000) begin errors++; $display("FAIL plus4_wrap got %h exp 00000000", Instr1_PC_Plus4_OUT); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push1(32'h7000 + i, 32'h00000700 + 4 * i);
        #2 RESET = 1'b0;
        #1;
        checks++; if (Count_OUT !== 4'd0 || Instr1_Valid_OUT !== 1'b0 || Full_OUT !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cnt=%0d v=%b f=%b exp 0/0/0", Count_OUT, Instr1_Valid_OUT, Full_OUT); end
        step();
        RESET = 1'b1;
        push1(32'h7100, 32'h00000800);
        checks++; if (Count_OUT !== 4'd1 || Instr1_PC_OUT !== 32'h00000800) begin errors++; $display("FAIL reset_mid_push got cnt=%0d pc=%h exp 1/00000800", Count_OUT, Instr1_PC_OUT); end
        drain();
    endtask

`ifdef QUEUE_BYPASS_EN
    task automatic test_bypass();
        Instr_IN = 32'h0000000C; Instr_PC_IN = 32'h00000900; Instr_Valid_IN = 1'b1; Request_Instr1 = 1'b1;
        #1;
        checks++; if (Instr1_OUT !== 32'h0000000C || Instr1_Valid_OUT !== 1'b1) begin errors++; $display("FAIL bypass_comb got %h v=%b exp 0000000C/1", Instr1_OUT, Instr1_Valid_OUT); end
        step();
        Instr_Valid_IN = 1'b0; Request_Instr1 = 1'b0;
        checks++; if (Count_OUT !== 4'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", Count_OUT); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_flush();
        test_freeze();
        test_back_to_back();
        test_plus4_wrap();
        test_reset_mid();
`ifdef QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
